// File: rtl/periph_pkg.sv
// periph_pkg: shared constants for the memory-mapped peripheral block.
// Holds the default window base, register byte offsets inside the 32-byte
// window, TCON bit positions and the widths of the narrow registers.
package periph_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h4000_0000;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LEDS    = 5'h0C;
  localparam logic [4:0] OFF_BCD7    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
  localparam int TCON_W  = 3;

  localparam int LED_W  = 8;
  localparam int BCD7_W = 12;

endpackage

// File: rtl/periph_timer.sv
// periph_timer: reloading up-counting timer with sticky interrupt status.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   wr_th_i/wr_tl_i/wr_tcon_i  decoded register write strobes
//   wdata_i                write data
//   th_o, tl_o, tcon_o     current register values for the read mux
//   irq_o                  interrupt request (TCON status bit)
module periph_timer
  import periph_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_th_i,
  input  logic              wr_tl_i,
  input  logic              wr_tcon_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       th_o,
  output logic [31:0]       tl_o,
  output logic [TCON_W-1:0] tcon_o,
  output logic              irq_o
);

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic              tl_max;
  logic              tick;
  logic              ovf;

  always_comb begin
    tl_max = (tl_q == 32'hFFFF_FFFF);
    // A software write to TL suppresses the whole timer update, including
    // the overflow event that would otherwise set the status bit.
    tick   = tcon_q[TCON_EN] && !wr_tl_i;
    ovf    = tick && tl_max;

    th_d = wr_th_i ? wdata_i : th_q;

    tl_d = tl_q;
    if (wr_tl_i) begin
      tl_d = wdata_i;
    end else if (tick) begin
      // th_q is the pre-edge value, so a same-cycle TH write reloads old TH
      tl_d = tl_max ? th_q : tl_q + 32'd1;
    end

    tcon_d = tcon_q;
    if (wr_tcon_i) begin
      tcon_d = wdata_i[TCON_W-1:0];
    end else if (ovf && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IS];

endmodule

// File: rtl/periph_bus.sv
// periph_bus: peripheral responder on the CPU data port for a 32-byte window.
// Registers: TH, TL, TCON (timer), LEDs, BCD7 drive, read-only SysTick.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   MemRd, MemWr    read / write strobes (same cycle as Addr)
//   Addr, WrData    byte address (word aligned) and write data
//   RdData          combinational read data, 0 unless MemRd && Hit
//   Hit             Addr falls inside the window
//   Irq             timer interrupt request
//   Leds            LED register
//   Bcd7            [7:0] segments, [11:8] digit enables
module periph_bus
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       RdData,
  output logic              Hit,
  output logic              Irq,
  output logic [LED_W-1:0]  Leds,
  output logic [BCD7_W-1:0] Bcd7
);

  logic [4:0]        off;
  logic              wr_en;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic [BCD7_W-1:0] bcd7_q, bcd7_d;
  logic [31:0]       systick_q, systick_d;
  logic [31:0]       th, tl;
  logic [TCON_W-1:0] tcon;

  assign Hit   = (Addr[31:5] == BASE_ADDR[31:5]);
  // Byte lane bits are masked so any Addr[1:0] selects the same word.
  assign off   = Addr[4:0] & 5'b11100;
  assign wr_en = MemWr && Hit;

  periph_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .wr_th_i   (wr_en && (off == OFF_TH)),
    .wr_tl_i   (wr_en && (off == OFF_TL)),
    .wr_tcon_i (wr_en && (off == OFF_TCON)),
    .wdata_i   (WrData),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (Irq)
  );

  always_comb begin
    leds_d    = (wr_en && off == OFF_LEDS) ? WrData[LED_W-1:0]  : leds_q;
    bcd7_d    = (wr_en && off == OFF_BCD7) ? WrData[BCD7_W-1:0] : bcd7_q;
    systick_d = systick_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q    <= '0;
      bcd7_q    <= '0;
      systick_q <= '0;
    end else begin
      leds_q    <= leds_d;
      bcd7_q    <= bcd7_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    RdData = 32'h0;
    if (MemRd && Hit) begin
      case (off)
        OFF_TH:      RdData = th;
        OFF_TL:      RdData = tl;
        OFF_TCON:    RdData = {{(32-TCON_W){1'b0}}, tcon};
        OFF_LEDS:    RdData = {{(32-LED_W){1'b0}}, leds_q};
        OFF_BCD7:    RdData = {{(32-BCD7_W){1'b0}}, bcd7_q};
        OFF_SYSTICK: RdData = systick_q;
        default:     RdData = 32'h0;
      endcase
    end
  end

  assign Leds = leds_q;
  assign Bcd7 = bcd7_q;

endmodule
